timer_apb_ctrl: RTL and testbench
=================================

Name: timer_apb_ctrl

Overview:
- APB slave front-end that sequences host accesses into the timer register block.
- Decodes and qualifies APB transfers, and inserts configurable wait states.
- Issues single-cycle wr_en/rd_en strobes to the register block and returns prdata/pslverr.
- Enforces access rules: unmapped or misaligned address, partial strobe, illegal divider value, divider reconfiguration while the timer runs.

Parameters:
- WAIT_CYCLES, 0, extra wait cycles inserted before pready (0..15); total wait states = WAIT_CYCLES+1.
- ADDR_MAX, 12'h01C, highest mapped word address (TCR..THCSR at 0x000..0x01C, word-aligned).

Ports:
- sys_clk  in  1  clock
- sys_rst_n  in  1  asynchronous active-low reset
- psel  in  1  APB select
- penable  in  1  APB enable (access phase)
- pwrite  in  1  1=write, 0=read
- paddr  in  12  byte address
- pwdata  in  32  write data
- pstrb  in  4  byte strobes
- pready  out  1  transfer complete
- prdata  out  32  read data
- pslverr  out  1  transfer error, valid only with pready
- wr_en  out  1  write strobe to register block
- rd_en  out  1  read strobe to register block
- addr  out  12  address to register block, equals paddr
- wdata  out  32  write data to register block, equals pwdata
- rdata  in  32  read data from register block
- timer_en_i  in  1  current TCR.timer_en
- div_en_i  in  1  current TCR.div_en
- div_val_i  in  4  current TCR.div_val

Behaviour:
- Reset: state=IDLE, wait counter=0. pready=0, pslverr=0, prdata=0, wr_en=0, rd_en=0.
- addr/wdata are combinational pass-through of paddr/pwdata.
- FSM states: IDLE, WAIT, RESP.
  - IDLE: when psel&penable, go to RESP if WAIT_CYCLES==0; otherwise go to WAIT with wcnt=1.
  - WAIT: if !psel, go to IDLE (aborted; no strobe, no pready). Else if wcnt==WAIT_CYCLES, go to RESP. Else wcnt++.
  - RESP: assert pready for exactly one cycle, then always go to IDLE.
- pready, wr_en, rd_en, pslverr and prdata are driven combinationally from state==RESP and the held APB signals. Latency: pready appears in access-phase cycle WAIT_CYCLES+2.
- err is computed in RESP and is the OR of:
  - paddr[1:0]!=0;
  - paddr>ADDR_MAX;
  - pwrite & pstrb!=4'hF;
  - pwrite & paddr==0x000 & pwdata[11:8]>8;
  - pwrite & paddr==0x000 & timer_en_i & (pwdata[11:8]!=div_val_i | pwdata[1]!=div_en_i).
- Clearing timer_en together with a divider change in one write while timer_en_i=1 is still an error. The whole write is dropped.
- In RESP:
  - wr_en = pwrite & !err;
  - rd_en = !pwrite & !err;
  - pslverr = err;
  - prdata = (!pwrite & !err) ? rdata : 0.
- Outside RESP: wr_en, rd_en, pslverr = 0 and prdata = 0.
- Reads are never blocked by timer_en_i. Reads ignore pstrb.
- Back-to-back transfers: after RESP the FSM is in IDLE. A new access phase is recognised no earlier than the cycle after the next setup phase, because a correct master drops penable after pready. penable held high in the cycle after RESP is not restarted unless psel&penable is seen in IDLE. Masters must return to setup phase, which the register block sees as at least one idle cycle.
- Reset asserted mid-transfer: FSM returns to IDLE immediately and all outputs go to 0. The master must restart the transfer.
- Exactly one wr_en or rd_en pulse per completed error-free transfer. Never more than one per transfer, including for WAIT_CYCLES=0.

Test Plan:
- WAIT_CYCLES=0: write 0x0000_0103 to 0x000 -> pready high in the 2nd access cycle; one-cycle wr_en with addr=0x000, wdata=0x103; pslverr=0.
- WAIT_CYCLES=3: read 0x00C after reset with rdata=0xFFFF_FFFF -> pready in the 5th access cycle; rd_en is one cycle coincident with pready; prdata=0xFFFF_FFFF.
- Write 0x900 to 0x000 (div_val=9) -> pslverr=1 with pready; wr_en never asserts.
- timer_en_i=1, div_val_i=1, div_en_i=1: write 0x0000_0203 to 0x000 -> pslverr=1, no wr_en. Write 0x0000_0102 -> pslverr=0, wr_en pulses (timer stop allowed).
- Accesses to 0x020, 0x006, and a write to 0x004 with pstrb=4'h3 -> each gives pslverr=1 and prdata=0, with no strobe.
- WAIT_CYCLES=2: drop psel in the 2nd access cycle -> FSM returns to IDLE; no pready, no wr_en. Asserting sys_rst_n=0 during WAIT forces all outputs to 0 at once.

Source files
------------

// File: rtl/timer_apb_ctrl.sv
// -----------------------------------------------------------------------------
// timer_apb_ctrl
//
// APB slave front-end for the timer register block. It qualifies each APB
// access, inserts WAIT_CYCLES+1 wait states, checks the access rules and then
// issues exactly one wr_en/rd_en strobe for a legal transfer. Illegal
// transfers complete with pslverr and produce no strobe.
//
// Ports:
//   sys_clk, sys_rst_n         clock, asynchronous active-low reset
//   psel, penable, pwrite      APB control
//   paddr, pwdata, pstrb       APB address / write data / byte strobes
//   pready, prdata, pslverr    APB response (driven only in the RESP state)
//   wr_en, rd_en               single-cycle strobes to the register block
//   addr, wdata                pass-through of paddr / pwdata
//   rdata                      read data from the register block
//   timer_en_i, div_en_i,      current TCR fields, used to guard divider
//   div_val_i                  reconfiguration while the timer runs
// -----------------------------------------------------------------------------
module timer_apb_ctrl #(
    parameter int unsigned WAIT_CYCLES = 0,
    parameter logic [11:0] ADDR_MAX    = 12'h01C
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        psel,
    input  logic        penable,
    input  logic        pwrite,
    input  logic [11:0] paddr,
    input  logic [31:0] pwdata,
    input  logic [3:0]  pstrb,
    output logic        pready,
    output logic [31:0] prdata,
    output logic        pslverr,
    output logic        wr_en,
    output logic        rd_en,
    output logic [11:0] addr,
    output logic [31:0] wdata,
    input  logic [31:0] rdata,
    input  logic        timer_en_i,
    input  logic        div_en_i,
    input  logic [3:0]  div_val_i
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_e;

    localparam logic [3:0]  WAIT_LIM = 4'(WAIT_CYCLES);
    localparam logic [11:0] TCR_ADDR = 12'h000;
    localparam logic [3:0]  DIV_MAX  = 4'd8;

    state_e     state_q, state_d;
    logic [3:0] wcnt_q,  wcnt_d;

    logic       err;
    logic       is_tcr_wr;
    logic [3:0] new_div_val;

    assign addr  = paddr;
    assign wdata = pwdata;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of its neighbours.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= S_IDLE;
            wcnt_q  <= 4'd0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
        end
    end

    // NOTE: every signal written here gets a default first so no path through
    // the case statement can leave it unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (psel && penable) begin
                    if (WAIT_CYCLES == 0) begin
                        state_d = S_RESP;
                    end else begin
                        state_d = S_WAIT;
                        wcnt_d  = 4'd1;
                    end
                end
            end
            S_WAIT: begin
                if (!psel) begin
                    // Master abandoned the transfer: nothing is issued.
                    state_d = S_IDLE;
                    wcnt_d  = 4'd0;
                end else if (wcnt_q == WAIT_LIM) begin
                    state_d = S_RESP;
                    wcnt_d  = 4'd0;
                end else begin
                    wcnt_d = wcnt_q + 4'd1;
                end
            end
            S_RESP: begin
                // Always back to IDLE; a following access must be seen anew
                // in IDLE, so one transfer can never produce two strobes.
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                wcnt_d  = 4'd0;
            end
        endcase
    end

    // Access-rule check. A TCR write that changes the divider while the timer
    // runs is rejected even if it also clears timer_en: the write is atomic.
    assign new_div_val = pwdata[11:8];
    assign is_tcr_wr   = pwrite && (paddr == TCR_ADDR);

    always_comb begin
        err = 1'b0;
        if (paddr[1:0] != 2'b00)                       err = 1'b1;
        if (paddr > ADDR_MAX)                          err = 1'b1;
        if (pwrite && (pstrb != 4'hF))                 err = 1'b1;
        if (is_tcr_wr && (new_div_val > DIV_MAX))      err = 1'b1;
        if (is_tcr_wr && timer_en_i &&
            ((new_div_val != div_val_i) || (pwdata[1] != div_en_i)))
                                                       err = 1'b1;
    end

    always_comb begin
        pready  = 1'b0;
        pslverr = 1'b0;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        prdata  = 32'h0;
        if (state_q == S_RESP) begin
            pready  = 1'b1;
            pslverr = err;
            wr_en   = pwrite && !err;
            rd_en   = !pwrite && !err;
            prdata  = (!pwrite && !err) ? rdata : 32'h0;
        end
    end

endmodule

// File: tb/tb_timer_apb_ctrl.sv
// -----------------------------------------------------------------------------
// tb_timer_apb_ctrl
//
// Three instances with WAIT_CYCLES = 0, 3 and 2 on independent APB buses that
// share one clock and reset. Each transfer pushes its expected response into a
// scoreboard queue; the entry is popped and compared when pready is observed.
// -----------------------------------------------------------------------------
module tb_timer_apb_ctrl;

    localparam int N_DUT   = 3;
    localparam int TIMEOUT = 40;

    typedef struct {
        int          lat;
        bit          err;
        bit          wr;
        logic [31:0] prdata;
        logic [11:0] addr;
        logic [31:0] wdata;
    } exp_t;

    int wait_cfg [N_DUT] = '{0, 3, 2};

    logic        sys_clk = 1'b0;
    logic        sys_rst_n;
    logic        psel       [N_DUT];
    logic        penable    [N_DUT];
    logic        pwrite     [N_DUT];
    logic [11:0] paddr      [N_DUT];
    logic [31:0] pwdata     [N_DUT];
    logic [3:0]  pstrb      [N_DUT];
    logic        pready     [N_DUT];
    logic [31:0] prdata     [N_DUT];
    logic        pslverr    [N_DUT];
    logic        wr_en      [N_DUT];
    logic        rd_en      [N_DUT];
    logic [11:0] addr       [N_DUT];
    logic [31:0] wdata      [N_DUT];
    logic [31:0] rdata      [N_DUT];
    logic        timer_en_i [N_DUT];
    logic        div_en_i   [N_DUT];
    logic [3:0]  div_val_i  [N_DUT];

    int   wr_cnt [N_DUT];
    int   rd_cnt [N_DUT];
    exp_t sb[$];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 sys_clk = ~sys_clk;

    timer_apb_ctrl #(.WAIT_CYCLES(0), .ADDR_MAX(12'h01C)) u_dut0 (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
        .psel(psel[0]), .penable(penable[0]), .pwrite(pwrite[0]),
        .paddr(paddr[0]), .pwdata(pwdata[0]), .pstrb(pstrb[0]),
        .pready(pready[0]), .prdata(prdata[0]), .pslverr(pslverr[0]),
        .wr_en(wr_en[0]), .rd_en(rd_en[0]), .addr(addr[0]), .wdata(wdata[0]),
        .rdata(rdata[0]), .timer_en_i(timer_en_i[0]), .div_en_i(div_en_i[0]),
        .div_val_i(div_val_i[0]));

    timer_apb_ctrl #(.WAIT_CYCLES(3), .ADDR_MAX(12'h01C)) u_dut1 (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
        .psel(psel[1]), .penable(penable[1]), .pwrite(pwrite[1]),
        .paddr(paddr[1]), .pwdata(pwdata[1]), .pstrb(pstrb[1]),
        .pready(pready[1]), .prdata(prdata[1]), .pslverr(pslverr[1]),
        .wr_en(wr_en[1]), .rd_en(rd_en[1]), .addr(addr[1]), .wdata(wdata[1]),
        .rdata(rdata[1]), .timer_en_i(timer_en_i[1]), .div_en_i(div_en_i[1]),
        .div_val_i(div_val_i[1]));

    timer_apb_ctrl #(.WAIT_CYCLES(2), .ADDR_MAX(12'h01C)) u_dut2 (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
        .psel(psel[2]), .penable(penable[2]), .pwrite(pwrite[2]),
        .paddr(paddr[2]), .pwdata(pwdata[2]), .pstrb(pstrb[2]),
        .pready(pready[2]), .prdata(prdata[2]), .pslverr(pslverr[2]),
        .wr_en(wr_en[2]), .rd_en(rd_en[2]), .addr(addr[2]), .wdata(wdata[2]),
        .rdata(rdata[2]), .timer_en_i(timer_en_i[2]), .div_en_i(div_en_i[2]),
        .div_val_i(div_val_i[2]));

    // Strobe counters, sampled at the clock edge (pre-update values).
    always @(posedge sys_clk) begin
        for (int d = 0; d < N_DUT; d++) begin
            if (wr_en[d] === 1'b1) wr_cnt[d] = wr_cnt[d] + 1;
            if (rd_en[d] === 1'b1) rd_cnt[d] = rd_cnt[d] + 1;
        end
    end

    // All five response outputs of one instance packed for a zero check.
    function automatic logic [35:0] resp_bits(input int d);
        return {pready[d], pslverr[d], wr_en[d], rd_en[d], prdata[d]};
    endfunction

    // One complete APB transfer on bus d. Entered at posedge+1; returns at
    // posedge+1 with psel/penable low, so calls may follow back to back.
    task automatic xfer(input int d, input bit wr, input logic [11:0] a,
                        input logic [31:0] wd, input logic [3:0] st,
                        input logic [31:0] rd, input bit exp_err,
                        input string name);
        exp_t e;
        exp_t got_e;
        int   lat;
        bit   got;
        e.lat    = wait_cfg[d] + 2;
        e.err    = exp_err;
        e.wr     = wr;
        e.prdata = (wr || exp_err) ? 32'h0 : rd;
        e.addr   = a;
        e.wdata  = wd;
        sb.push_back(e);

        wr_cnt[d] = 0;
        rd_cnt[d] = 0;
        rdata[d]   = rd;
        psel[d]    = 1'b1;
        penable[d] = 1'b0;
        pwrite[d]  = wr;
        paddr[d]   = a;
        pwdata[d]  = wd;
        pstrb[d]   = st;
        @(posedge sys_clk); #1;
        penable[d] = 1'b1;
        lat = 0;
        got = 0;
        while (!got && lat < TIMEOUT) begin
            lat++;
            @(negedge sys_clk);
            if (pready[d] === 1'b1) begin
                got   = 1;
                got_e = sb.pop_front();
                n_checks++;
                if (lat !== got_e.lat) begin
                    n_fail++;
                    $display("FAIL %s latency: got %0d expected %0d", name, lat, got_e.lat);
                end
                n_checks++;
                if (pslverr[d] !== got_e.err) begin
                    n_fail++;
                    $display("FAIL %s pslverr: got %b expected %b", name, pslverr[d], got_e.err);
                end
                n_checks++;
                if (prdata[d] !== got_e.prdata) begin
                    n_fail++;
                    $display("FAIL %s prdata: got %h expected %h", name, prdata[d], got_e.prdata);
                end
                n_checks++;
                if (wr_en[d] !== (got_e.wr && !got_e.err)) begin
                    n_fail++;
                    $display("FAIL %s wr_en at pready: got %b expected %b", name, wr_en[d], got_e.wr && !got_e.err);
                end
                n_checks++;
                if (rd_en[d] !== (!got_e.wr && !got_e.err)) begin
                    n_fail++;
                    $display("FAIL %s rd_en at pready: got %b expected %b", name, rd_en[d], !got_e.wr && !got_e.err);
                end
                n_checks++;
                if (addr[d] !== got_e.addr || wdata[d] !== got_e.wdata) begin
                    n_fail++;
                    $display("FAIL %s addr/wdata: got %h/%h expected %h/%h", name, addr[d], wdata[d], got_e.addr, got_e.wdata);
                end
            end else begin
                @(posedge sys_clk); #1;
            end
        end
        if (!got) begin
            got_e = sb.pop_front();
            n_checks++;
            n_fail++;
            $display("FAIL %s timeout: no pready within %0d cycles", name, TIMEOUT);
        end
        @(posedge sys_clk); #1;
        psel[d]    = 1'b0;
        penable[d] = 1'b0;
        n_checks++;
        if (wr_cnt[d] !== ((wr && !exp_err) ? 1 : 0) || rd_cnt[d] !== ((!wr && !exp_err) ? 1 : 0)) begin
            n_fail++;
            $display("FAIL %s strobe count: got wr=%0d rd=%0d expected wr=%0d rd=%0d", name,
                     wr_cnt[d], rd_cnt[d], (wr && !exp_err) ? 1 : 0, (!wr && !exp_err) ? 1 : 0);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge sys_clk); #1;
        end
    endtask

    task automatic test_reset();
        sys_rst_n = 1'b0;
        for (int d = 0; d < N_DUT; d++) begin
            psel[d] = 1'b1; penable[d] = 1'b1; pwrite[d] = 1'b0;
            paddr[d] = 12'h004; pwdata[d] = 32'h0; pstrb[d] = 4'hF;
            rdata[d] = 32'hA5A5_A5A5;
            timer_en_i[d] = 1'b0; div_en_i[d] = 1'b0; div_val_i[d] = 4'd0;
            wr_cnt[d] = 0; rd_cnt[d] = 0;
        end
        repeat (3) @(posedge sys_clk);
        @(negedge sys_clk);
        for (int d = 0; d < N_DUT; d++) begin
            n_checks++;
            if (resp_bits(d) !== 36'h0) begin
                n_fail++;
                $display("FAIL reset_outputs dut%0d: got %h expected 0", d, resp_bits(d));
            end
            psel[d] = 1'b0; penable[d] = 1'b0;
        end
        sys_rst_n = 1'b1;
        idle(2);
    endtask

    task automatic test_basic();
        xfer(0, 1'b1, 12'h000, 32'h0000_0103, 4'hF, 32'h0, 1'b0, "w0_write_tcr");
        idle(1);
        xfer(1, 1'b0, 12'h00C, 32'h0, 4'hF, 32'hFFFF_FFFF, 1'b0, "w3_read_00c");
        idle(1);
        xfer(2, 1'b0, 12'h010, 32'h0, 4'h0, 32'h1234_5678, 1'b0, "w2_read_nostrb");
        idle(1);
    endtask

    task automatic test_divider();
        xfer(0, 1'b1, 12'h000, 32'h0000_0900, 4'hF, 32'h0, 1'b1, "div9_illegal");
        xfer(0, 1'b1, 12'h000, 32'h0000_0800, 4'hF, 32'h0, 1'b0, "div8_legal");
        timer_en_i[0] = 1'b1; div_en_i[0] = 1'b1; div_val_i[0] = 4'd1;
        xfer(0, 1'b1, 12'h000, 32'h0000_0203, 4'hF, 32'h0, 1'b1, "run_div_change");
        xfer(0, 1'b1, 12'h000, 32'h0000_0202, 4'hF, 32'h0, 1'b1, "run_stop_and_change");
        xfer(0, 1'b1, 12'h000, 32'h0000_0101, 4'hF, 32'h0, 1'b1, "run_div_en_change");
        xfer(0, 1'b1, 12'h000, 32'h0000_0102, 4'hF, 32'h0, 1'b0, "run_stop_allowed");
        xfer(0, 1'b0, 12'h000, 32'h0, 4'hF, 32'h0000_0103, 1'b0, "run_read_tcr");
        xfer(0, 1'b1, 12'h004, 32'h0000_0F00, 4'hF, 32'h0, 1'b0, "run_write_other");
        timer_en_i[0] = 1'b0; div_en_i[0] = 1'b0; div_val_i[0] = 4'd0;
        idle(1);
    endtask

    task automatic test_access_rules();
        xfer(0, 1'b0, 12'h020, 32'h0, 4'hF, 32'hDEAD_BEEF, 1'b1, "read_unmapped");
        xfer(0, 1'b0, 12'h006, 32'h0, 4'hF, 32'hDEAD_BEEF, 1'b1, "read_misaligned");
        xfer(0, 1'b1, 12'h004, 32'h1111_2222, 4'h3, 32'h0, 1'b1, "write_partial_strb");
        xfer(0, 1'b0, 12'h01C, 32'h0, 4'hF, 32'hCAFE_0001, 1'b0, "read_last_reg");
        xfer(1, 1'b1, 12'h020, 32'h5, 4'hF, 32'h0, 1'b1, "w3_write_unmapped");
        idle(1);
    endtask

    task automatic test_back_to_back();
        xfer(0, 1'b1, 12'h008, 32'h0000_00AA, 4'hF, 32'h0, 1'b0, "b2b_w0_a");
        xfer(0, 1'b1, 12'h00C, 32'h0000_00BB, 4'hF, 32'h0, 1'b0, "b2b_w0_b");
        xfer(0, 1'b0, 12'h014, 32'h0, 4'hF, 32'h0000_0077, 1'b0, "b2b_w0_c");
        xfer(1, 1'b0, 12'h018, 32'h0, 4'hF, 32'h0000_0042, 1'b0, "b2b_w3_a");
        xfer(1, 1'b1, 12'h018, 32'h0000_0099, 4'hF, 32'h0, 1'b0, "b2b_w3_b");
        idle(1);
    endtask

    task automatic test_abort();
        bit seen_ready;
        wr_cnt[2] = 0; rd_cnt[2] = 0;
        psel[2] = 1'b1; penable[2] = 1'b0; pwrite[2] = 1'b1;
        paddr[2] = 12'h008; pwdata[2] = 32'h0000_0055; pstrb[2] = 4'hF;
        @(posedge sys_clk); #1;
        penable[2] = 1'b1;
        @(posedge sys_clk); #1;
        psel[2] = 1'b0; penable[2] = 1'b0;
        seen_ready = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge sys_clk);
            if (pready[2] === 1'b1) seen_ready = 1;
        end
        n_checks++;
        if (seen_ready !== 1'b0 || wr_cnt[2] !== 0) begin
            n_fail++;
            $display("FAIL abort: got pready_seen=%b wr_cnt=%0d expected 0/0", seen_ready, wr_cnt[2]);
        end
        @(posedge sys_clk); #1;
        xfer(2, 1'b1, 12'h008, 32'h0000_0066, 4'hF, 32'h0, 1'b0, "after_abort");
        idle(1);
    endtask

    task automatic test_reset_mid();
        bit got;
        psel[2] = 1'b1; penable[2] = 1'b0; pwrite[2] = 1'b1;
        paddr[2] = 12'h008; pwdata[2] = 32'h0000_0033; pstrb[2] = 4'hF;
        @(posedge sys_clk); #1;
        penable[2] = 1'b1;
        @(posedge sys_clk); #1;
        @(negedge sys_clk);
        sys_rst_n = 1'b0;
        #1;
        n_checks++;
        if (resp_bits(2) !== 36'h0) begin
            n_fail++;
            $display("FAIL reset_in_wait: got %h expected 0", resp_bits(2));
        end
        @(posedge sys_clk);
        @(negedge sys_clk);
        n_checks++;
        if (resp_bits(2) !== 36'h0) begin
            n_fail++;
            $display("FAIL reset_held: got %h expected 0", resp_bits(2));
        end
        psel[2] = 1'b0; penable[2] = 1'b0;
        sys_rst_n = 1'b1;
        @(posedge sys_clk); #1;

        // Reset hitting the RESP cycle must drop pready and wr_en immediately.
        psel[2] = 1'b1; penable[2] = 1'b0;
        @(posedge sys_clk); #1;
        penable[2] = 1'b1;
        got = 0;
        for (int i = 0; i < TIMEOUT && !got; i++) begin
            @(negedge sys_clk);
            if (pready[2] === 1'b1) got = 1;
            else begin
                @(posedge sys_clk); #1;
            end
        end
        n_checks++;
        if (!got) begin
            n_fail++;
            $display("FAIL reset_in_resp: no pready within %0d cycles", TIMEOUT);
        end
        sys_rst_n = 1'b0;
        #1;
        n_checks++;
        if (resp_bits(2) !== 36'h0) begin
            n_fail++;
            $display("FAIL reset_in_resp outputs: got %h expected 0", resp_bits(2));
        end
        psel[2] = 1'b0; penable[2] = 1'b0;
        @(posedge sys_clk);
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        @(posedge sys_clk); #1;
        xfer(2, 1'b0, 12'h004, 32'h0, 4'hF, 32'h0BAD_F00D, 1'b0, "after_reset_read");
        idle(1);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_divider();
        test_access_rules();
        test_back_to_back();
        test_abort();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
